// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller: Decode operand fields (d_ra, d_rb, d_use_ra, d_use_rb),
//     Execute control fields (ex_rd, ex_rw, ex_mr, ex_br_taken, ex_hlt), irq.
//   Controller -> datapath: pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush,
//     int_save, int_ack, halted, stall_cnt.
// master: datapath side. slave: hazard controller side.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 2
) ();
    logic [REG_W-1:0] d_ra;
    logic [REG_W-1:0] d_rb;
    logic             d_use_ra;
    logic             d_use_rb;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rw;
    logic             ex_mr;
    logic             ex_br_taken;
    logic             ex_hlt;
    logic             irq;

    logic             pc_ld;
    logic [1:0]       pc_sel;
    logic             fd_ld;
    logic             fd_flush;
    logic             dex_ld;
    logic             dex_flush;
    logic             int_save;
    logic             int_ack;
    logic             halted;
    logic [7:0]       stall_cnt;

    modport master (
        output d_ra, d_rb, d_use_ra, d_use_rb, ex_rd, ex_rw, ex_mr, ex_br_taken, ex_hlt, irq,
        input  pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush, int_save, int_ack, halted,
               stall_cnt
    );

    modport slave (
        input  d_ra, d_rb, d_use_ra, d_use_rb, ex_rd, ex_rw, ex_mr, ex_br_taken, ex_hlt, irq,
        output pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush, int_save, int_ack, halted,
               stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller beside the D/Ex latch.
//   Generates PC / F-D / D-Ex load and flush strobes, inserts a bubble on load-use
//   hazards, squashes wrong-path work on taken branches, parks on HLT and runs a
//   multi-cycle interrupt entry (int_save ... int_ack over INT_CYCLES cycles).
// Ports:
//   clk     - clock, posedge
//   reset   - asynchronous active-high reset
//   ctrl_io - hazard_ctrl_if.slave: Decode/Execute fields and irq in, strobes out
// Outputs are combinational from registered state and current inputs; reset forces
// them to the safe "everything flushed, nothing loaded" pattern immediately.
module hazard_ctrl #(
    parameter int unsigned REG_W      = 2,
    parameter int unsigned INT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  ctrl_io
);

    localparam int unsigned IcntW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
    localparam logic [IcntW-1:0] IcntLast = IcntW'(INT_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StHalted, StInt} state_e;

    state_e           state_q, state_d;
    logic             irq_q;
    logic             pend_q, pend_d;
    logic [IcntW-1:0] icnt_q, icnt_d;
    logic [7:0]       stall_q, stall_d;

    logic [REG_W-1:0] d_ra, d_rb, ex_rd;
    logic             lu;
    logic             irq_edge;
    logic             ack;

    assign d_ra  = ctrl_io.d_ra;
    assign d_rb  = ctrl_io.d_rb;
    assign ex_rd = ctrl_io.ex_rd;

    assign lu = ctrl_io.ex_mr & ctrl_io.ex_rw &
                ((ctrl_io.d_use_ra & (d_ra == ex_rd)) | (ctrl_io.d_use_rb & (d_rb == ex_rd)));
    assign irq_edge = ctrl_io.irq & ~irq_q;

    always_comb begin
        ctrl_io.pc_ld     = 1'b1;
        ctrl_io.pc_sel    = 2'b00;
        ctrl_io.fd_ld     = 1'b1;
        ctrl_io.fd_flush  = 1'b0;
        ctrl_io.dex_ld    = 1'b1;
        ctrl_io.dex_flush = 1'b0;
        ctrl_io.int_save  = 1'b0;
        ctrl_io.halted    = 1'b0;
        ack               = 1'b0;
        state_d           = state_q;
        icnt_d            = icnt_q;
        stall_d           = stall_q;

        unique case (state_q)
            StRun: begin
                if (ctrl_io.ex_br_taken) begin
                    // Pending interrupt waits so the saved PC is the branch target.
                    ctrl_io.pc_sel    = 2'b01;
                    ctrl_io.fd_flush  = 1'b1;
                    ctrl_io.dex_flush = 1'b1;
                end else if (pend_q) begin
                    ctrl_io.pc_ld     = 1'b0;
                    ctrl_io.fd_flush  = 1'b1;
                    ctrl_io.dex_flush = 1'b1;
                    ctrl_io.int_save  = 1'b1;
                    state_d           = StInt;
                    icnt_d            = IcntW'(1);
                end else if (ctrl_io.ex_hlt) begin
                    ctrl_io.pc_ld     = 1'b0;
                    ctrl_io.fd_ld     = 1'b0;
                    ctrl_io.dex_flush = 1'b1;
                    state_d           = StHalted;
                end else if (lu) begin
                    ctrl_io.pc_ld     = 1'b0;
                    ctrl_io.fd_ld     = 1'b0;
                    ctrl_io.dex_flush = 1'b1;
                    stall_d           = (stall_q == 8'hff) ? stall_q : stall_q + 8'd1;
                end
            end
            StHalted: begin
                ctrl_io.halted    = 1'b1;
                ctrl_io.pc_ld     = 1'b0;
                ctrl_io.fd_ld     = 1'b0;
                ctrl_io.dex_flush = 1'b1;
                if (pend_q) begin
                    ctrl_io.fd_flush = 1'b1;
                    ctrl_io.int_save = 1'b1;
                    state_d          = StInt;
                    icnt_d           = IcntW'(1);
                end
            end
            StInt: begin
                ctrl_io.pc_ld     = 1'b0;
                ctrl_io.fd_flush  = 1'b1;
                ctrl_io.dex_flush = 1'b1;
                if (icnt_q == IcntLast) begin
                    ctrl_io.pc_sel = 2'b10;
                    ctrl_io.pc_ld  = 1'b1;
                    ack            = 1'b1;
                    state_d        = StRun;
                    icnt_d         = '0;
                end else begin
                    icnt_d = icnt_q + IcntW'(1);
                end
            end
            default: begin
                state_d = StRun;
                icnt_d  = '0;
            end
        endcase

        // A fresh edge in the acknowledge cycle must survive the clear.
        pend_d = irq_edge | (pend_q & ~ack);

        ctrl_io.int_ack = ack;

        if (reset) begin
            ctrl_io.pc_ld     = 1'b0;
            ctrl_io.pc_sel    = 2'b00;
            ctrl_io.fd_ld     = 1'b0;
            ctrl_io.fd_flush  = 1'b1;
            ctrl_io.dex_ld    = 1'b0;
            ctrl_io.dex_flush = 1'b1;
            ctrl_io.int_save  = 1'b0;
            ctrl_io.int_ack   = 1'b0;
            ctrl_io.halted    = 1'b0;
        end
    end

    assign ctrl_io.stall_cnt = stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
            icnt_q  <= '0;
            stall_q <= 8'd0;
        end else begin
            state_q <= state_d;
            irq_q   <= ctrl_io.irq;
            pend_q  <= pend_d;
            icnt_q  <= icnt_d;
            stall_q <= stall_d;
        end
    end

endmodule
